// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling 8N1 UART receiver feeding a first-word fall-through FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic [7:0]                   m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         frame_err,
  output logic                         overflow
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_sc;
  logic [3:0]       w_sc_nxt;
  logic [2:0]       r_bi;
  logic [2:0]       w_bi_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_push;
  logic             w_ferr;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;
  logic             r_frame_err;
  logic             r_overflow;

  // Two-flop synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_div == DIV_W'(DIV - 1));

  // Free-running oversample tick divider, independent of the receiver state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sc    <= '0;
      r_bi    <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
      r_bi    <= w_bi_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Receiver next state: mid-start check at sample 7, mid-bit samples at 15
  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_bi_nxt    = r_bi;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_sync2) begin
            w_state_nxt = S_START;
            w_sc_nxt    = '0;
          end
        end
        S_START: begin
          if (r_sc == 4'd7) begin
            w_sc_nxt = '0;
            w_bi_nxt = '0;
            // A line that is already high again at mid-start was a glitch
            w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
          end else begin
            w_sc_nxt = r_sc + 4'd1;
          end
        end
        S_DATA: begin
          if (r_sc == 4'd15) begin
            w_sc_nxt    = '0;
            w_shift_nxt = {r_sync2, r_shift[7:1]};
            if (r_bi == 3'd7) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bi_nxt = r_bi + 3'd1;
            end
          end else begin
            w_sc_nxt = r_sc + 4'd1;
          end
        end
        S_STOP: begin
          if (r_sc == 4'd15) begin
            w_sc_nxt    = '0;
            w_state_nxt = S_IDLE;
            w_push      = r_sync2;
            w_ferr      = !r_sync2;
          end else begin
            w_sc_nxt = r_sc + 4'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte
  assign w_wr_en = w_push && (!w_full || w_pop);

  // FIFO storage and pointers, plus the registered status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_frame_err <= w_ferr;
      r_overflow  <= w_push && !w_wr_en;
    end
  end

  assign m_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign m_valid   = !w_empty;
  assign count     = r_wr_ptr - r_rd_ptr;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 640_000;
  localparam int BAUD     = 10_000;
  localparam int OVS      = 16;
  localparam int DEPTH    = 8;
  localparam int DIV      = CLK_FREQ / (BAUD * OVS);
  localparam int BIT      = DIV * OVS;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] count;
  logic       frame_err;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int cyc = 0;
  int start_cyc = 0;
  int valid_rise_cyc = -1;
  logic prev_valid = 1'b0;
  int ferr_hi = 0;
  int ovf_hi = 0;
  int snap_f;
  int snap_o;
  int lat;

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .frame_err(frame_err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_err === 1'b1) ferr_hi++;
      if (overflow === 1'b1) ovf_hi++;
      if (m_valid === 1'b1 && prev_valid !== 1'b1) valid_rise_cyc = cyc;
    end
    prev_valid = m_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit expect_push);
    if (expect_push) exp_q.push_back(d);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (BIT * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (BIT / 4) @(negedge clk);
    end
    repeat (BIT) @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_valid !== 1'b1) begin
        check("drain_valid", m_valid, 1);
        break;
      end
      if (exp_q.size() == 0) begin
        check("sb_size", exp_q.size(), 1);
        break;
      end
      check("drain_data", m_data, exp_q.pop_front());
      m_ready = 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b0;
    check("drain_empty", m_valid, 0);
    check("drain_count", count, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    m_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_count", count, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    begin
      int vhi = 0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (m_valid !== 1'b0) vhi++;
      end
      check("idle_no_valid", vhi, 0);
    end

    // single byte with latency window around 9.5 bit times
    valid_rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 1'b1);
    check("single_valid", m_valid, 1);
    check("single_count", count, 1);
    lat = valid_rise_cyc - start_cyc;
    check($sformatf("latency_window lat=%0d", lat),
          (lat >= BIT * 19 / 2 - DIV) && (lat <= BIT * 19 / 2 + DIV + 4), 1);
    drain(1);

    // short low glitch is rejected
    snap_f = ferr_hi;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT * 3 / 10) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch_count", count, 0);
    check("glitch_valid", m_valid, 0);
    check("glitch_no_ferr", ferr_hi - snap_f, 0);

    // framing error: stop bit low
    snap_f = ferr_hi;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (BIT) @(negedge clk);
    check("ferr_one_cycle", ferr_hi - snap_f, 1);
    check("ferr_count", count, 0);
    check("ferr_valid", m_valid, 0);

    // overflow on the ninth byte
    snap_o = ovf_hi;
    for (int b = 0; b < 8; b++) send_frame(8'(b), 1'b1, 1'b1);
    check("fill_count", count, 8);
    check("fill_no_ovf", ovf_hi - snap_o, 0);
    send_frame(8'h08, 1'b1, 1'b0);
    check("ovf_one_cycle", ovf_hi - snap_o, 1);
    check("ovf_count", count, 8);
    drain(8);

    // full FIFO with a pop exactly on the push edge
    snap_o = ovf_hi;
    for (int b = 0; b < 8; b++) send_frame(8'(8'h10 + b), 1'b1, 1'b1);
    check("full2_count", count, 8);
    fork
      send_frame(8'h18, 1'b1, 1'b1);
      begin
        int w = 0;
        while (dut.w_push !== 1'b1 && w < 12 * BIT) begin
          @(negedge clk);
          w++;
        end
        check("push_edge_seen", dut.w_push, 1);
        if (dut.w_push === 1'b1 && exp_q.size() > 0) begin
          check("pop_at_push_data", m_data, exp_q.pop_front());
          m_ready = 1'b1;
          @(negedge clk);
          m_ready = 1'b0;
        end
      end
    join
    check("simul_no_ovf", ovf_hi - snap_o, 0);
    check("simul_count", count, 8);
    drain(8);

    // reset during bit 4 of 0x55
    snap_f = ferr_hi;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b0 : 1'b1;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check("midrst_count", count, 0);
    check("midrst_valid", m_valid, 0);
    check("midrst_no_ferr", ferr_hi - snap_f, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    check("after_rst_count", count, 1);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
